// File: rtl/execute_reg.sv
// execute_reg: Y86-64 decode->execute pipeline register with hazard control and event counters
//   in : clk, rst_n (async active-low), d_* decode fields, e_Cnd, M_icode, W_stat
//   out: E_* register fields, F_stall/D_stall/D_bubble/E_bubble, bubble_cnt/stall_cnt
module execute_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       d_stat,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_ifun,
  input  logic [63:0]      d_valC,
  input  logic [63:0]      d_valA,
  input  logic [63:0]      d_valB,
  input  logic [3:0]       d_dstE,
  input  logic [3:0]       d_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       W_stat,
  output logic [3:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [63:0]      E_valC,
  output logic [63:0]      E_valA,
  output logic [63:0]      E_valB,
  output logic [3:0]       E_dstE,
  output logic [3:0]       E_dstM,
  output logic [3:0]       E_srcA,
  output logic [3:0]       E_srcB,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [3:0] AOK = 4'h1, NOP = 4'h1, JXX = 4'h7, MRMOVQ = 4'h5, POPQ = 4'hB, RET = 4'h9, RNONE = 4'hF;
  logic [3:0]       r_stat, r_icode, r_ifun, r_dstE, r_dstM, r_srcA, r_srcB;
  logic [63:0]      r_valC, r_valA, r_valB;
  logic [CNT_W-1:0] r_bubble_cnt, r_stall_cnt;
  logic             w_load_use, w_mispredict, w_ret_haz, w_freeze;
  always_comb begin
    w_load_use   = (r_icode == MRMOVQ || r_icode == POPQ) && r_dstM != RNONE && (r_dstM == d_srcA || r_dstM == d_srcB);
    w_mispredict = r_icode == JXX && !e_Cnd;
    w_ret_haz    = d_icode == RET || r_icode == RET || M_icode == RET;
    w_freeze     = W_stat != AOK;
    F_stall      = w_load_use || w_ret_haz;
    D_stall      = w_load_use;
    D_bubble     = w_mispredict || (w_ret_haz && !w_load_use);
    E_bubble     = (w_mispredict || w_load_use) && !w_freeze;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat  <= AOK;
      r_icode <= NOP;
      r_ifun  <= 4'h0;
      r_valC  <= '0;
      r_valA  <= '0;
      r_valB  <= '0;
      r_dstE  <= RNONE;
      r_dstM  <= RNONE;
      r_srcA  <= RNONE;
      r_srcB  <= RNONE;
    end else if (!w_freeze) begin
      r_stat  <= E_bubble ? AOK   : d_stat;
      r_icode <= E_bubble ? NOP   : d_icode;
      r_ifun  <= E_bubble ? 4'h0  : d_ifun;
      r_valC  <= E_bubble ? '0    : d_valC;
      r_valA  <= E_bubble ? '0    : d_valA;
      r_valB  <= E_bubble ? '0    : d_valB;
      r_dstE  <= E_bubble ? RNONE : d_dstE;
      r_dstM  <= E_bubble ? RNONE : d_dstM;
      r_srcA  <= E_bubble ? RNONE : d_srcA;
      r_srcB  <= E_bubble ? RNONE : d_srcB;
    end
  end
  // E_bubble is already gated by freeze; stall counting needs its own gate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (E_bubble && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 1'b1;
      if (F_stall && !w_freeze && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
  assign E_stat     = r_stat;
  assign E_icode    = r_icode;
  assign E_ifun     = r_ifun;
  assign E_valC     = r_valC;
  assign E_valA     = r_valA;
  assign E_valB     = r_valB;
  assign E_dstE     = r_dstE;
  assign E_dstM     = r_dstM;
  assign E_srcA     = r_srcA;
  assign E_srcB     = r_srcB;
  assign bubble_cnt = r_bubble_cnt;
  assign stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_execute_reg.sv
// tb_execute_reg: table-driven check of execute_reg pass-through, hazards, freeze and counters
module tb_execute_reg;
  localparam int CW = 4;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic [3:0]    d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB, M_icode, W_stat;
  logic [63:0]   d_valC, d_valA, d_valB;
  logic          e_Cnd;
  logic [3:0]    E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0]   E_valC, E_valA, E_valB;
  logic          F_stall, D_stall, D_bubble, E_bubble;
  logic [CW-1:0] bubble_cnt, stall_cnt;
  int total = 0, bad = 0;

  execute_reg #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd), .M_icode(M_icode), .W_stat(W_stat),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA),
    .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ic; logic [63:0] va, vb; logic [3:0] de, dm, sa, sb;
    logic cnd; logic [3:0] mi, ws;
    logic [3:0] ctl;
    logic [3:0] eic; logic [63:0] eva, evb; logic [3:0] edm; int bc, sc;
  } vec_t;

  vec_t v[20];

  task automatic chk(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    d_stat = 4'h1; d_ifun = 4'h0; d_valC = 64'h1234;
    d_icode = x.ic; d_valA = x.va; d_valB = x.vb; d_dstE = x.de; d_dstM = x.dm;
    d_srcA = x.sa; d_srcB = x.sb; e_Cnd = x.cnd; M_icode = x.mi; W_stat = x.ws;
  endtask

  task automatic simple(input logic [3:0] ic, input logic cnd, input logic [3:0] mi);
    @(negedge clk);
    d_icode = ic; d_srcA = 4'hF; d_srcB = 4'hF; d_dstM = 4'hF; e_Cnd = cnd; M_icode = mi; W_stat = 4'h1;
    @(posedge clk);
  endtask

  initial begin
    //      ic     va    vb   de    dm    sa    sb   cnd  mi    ws    ctl       eic   eva   evb  edm   bc sc
    v[0]  = '{4'h6, -143, 101, 4'h3, 4'hF, 4'h2, 4'h5, 0, 4'h1, 4'h1, 4'b0000, 4'h6, -143, 101, 4'hF, 0, 0};
    v[1]  = '{4'h5, 0,    7,   4'hF, 4'h3, 4'hF, 4'h4, 0, 4'h1, 4'h1, 4'b0000, 4'h5, 0,    7,   4'h3, 0, 0};
    v[2]  = '{4'h6, 11,   22,  4'h3, 4'hF, 4'h1, 4'h3, 0, 4'h1, 4'h1, 4'b1101, 4'h1, 0,    0,   4'hF, 1, 1};
    v[3]  = '{4'h6, 11,   22,  4'h3, 4'hF, 4'h1, 4'h3, 0, 4'h1, 4'h1, 4'b0000, 4'h6, 11,   22,  4'hF, 1, 1};
    v[4]  = '{4'h7, 0,    0,   4'hF, 4'hF, 4'hF, 4'hF, 0, 4'h1, 4'h1, 4'b0000, 4'h7, 0,    0,   4'hF, 1, 1};
    v[5]  = '{4'h6, 5,    6,   4'h3, 4'hF, 4'hF, 4'hF, 0, 4'h1, 4'h1, 4'b0011, 4'h1, 0,    0,   4'hF, 2, 1};
    v[6]  = '{4'h7, 0,    0,   4'hF, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 4'b0000, 4'h7, 0,    0,   4'hF, 2, 1};
    v[7]  = '{4'h6, 9,    10,  4'h3, 4'hF, 4'hF, 4'hF, 1, 4'h1, 4'h1, 4'b0000, 4'h6, 9,    10,  4'hF, 2, 1};
    v[8]  = '{4'h6, 20,   0,   4'h2, 4'hF, 4'hF, 4'hF, 0, 4'h9, 4'h1, 4'b1010, 4'h6, 20,   0,   4'hF, 2, 2};
    v[9]  = '{4'h6, 21,   0,   4'h2, 4'hF, 4'hF, 4'hF, 0, 4'h9, 4'h1, 4'b1010, 4'h6, 21,   0,   4'hF, 2, 3};
    v[10] = '{4'h6, 22,   0,   4'h2, 4'hF, 4'hF, 4'hF, 0, 4'h9, 4'h1, 4'b1010, 4'h6, 22,   0,   4'hF, 2, 4};
    v[11] = '{4'hB, 8,    8,   4'h4, 4'h5, 4'h4, 4'h4, 0, 4'h1, 4'h1, 4'b0000, 4'hB, 8,    8,   4'h5, 2, 4};
    v[12] = '{4'h9, 0,    0,   4'hF, 4'hF, 4'h4, 4'h5, 0, 4'h1, 4'h1, 4'b1101, 4'h1, 0,    0,   4'hF, 3, 5};
    v[13] = '{4'h9, 0,    0,   4'hF, 4'hF, 4'h4, 4'h4, 0, 4'h1, 4'h1, 4'b1010, 4'h9, 0,    0,   4'hF, 3, 6};
    v[14] = '{4'h1, 0,    0,   4'hF, 4'hF, 4'hF, 4'hF, 0, 4'h1, 4'h1, 4'b1010, 4'h1, 0,    0,   4'hF, 3, 7};
    v[15] = '{4'h5, 0,    0,   4'hF, 4'h6, 4'hF, 4'h2, 0, 4'h1, 4'h1, 4'b0000, 4'h5, 0,    0,   4'h6, 3, 7};
    v[16] = '{4'h6, 77,   0,   4'h3, 4'hF, 4'h6, 4'hF, 0, 4'h1, 4'h2, 4'b1100, 4'h5, 0,    0,   4'h6, 3, 7};
    v[17] = '{4'h6, 77,   0,   4'h3, 4'hF, 4'h6, 4'hF, 0, 4'h1, 4'h1, 4'b1101, 4'h1, 0,    0,   4'hF, 4, 8};
    v[18] = '{4'h5, 3,    0,   4'hF, 4'hF, 4'hF, 4'hF, 0, 4'h1, 4'h1, 4'b0000, 4'h5, 3,    0,   4'hF, 4, 8};
    v[19] = '{4'h6, 4,    0,   4'h3, 4'hF, 4'hF, 4'hF, 0, 4'h1, 4'h1, 4'b0000, 4'h6, 4,    0,   4'hF, 4, 8};

    d_stat = 4'($urandom); d_icode = 4'($urandom_range(0, 8)); d_ifun = 4'($urandom);
    d_valC = {$urandom, $urandom}; d_valA = {$urandom, $urandom}; d_valB = {$urandom, $urandom};
    d_dstE = 4'($urandom); d_dstM = 4'($urandom); d_srcA = 4'($urandom); d_srcB = 4'($urandom);
    e_Cnd = 1'b0; M_icode = 4'h1; W_stat = 4'h1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_icode", 0, 64'(E_icode), 64'h1);
    chk("rst_stat", 0, 64'(E_stat), 64'h1);
    chk("rst_dstE", 0, 64'(E_dstE), 64'hF);
    chk("rst_dstM", 0, 64'(E_dstM), 64'hF);
    chk("rst_valA", 0, E_valA, 64'h0);
    chk("rst_valC", 0, E_valC, 64'h0);
    chk("rst_bcnt", 0, 64'(bubble_cnt), 64'h0);
    chk("rst_scnt", 0, 64'(stall_cnt), 64'h0);
    chk("rst_ctl", 0, 64'({F_stall, D_stall, D_bubble, E_bubble}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(v[i]);
      #1;
      chk("ctl", i, 64'({F_stall, D_stall, D_bubble, E_bubble}), 64'(v[i].ctl));
      @(posedge clk);
      #1;
      chk("E_icode", i, 64'(E_icode), 64'(v[i].eic));
      chk("E_valA", i, E_valA, v[i].eva);
      chk("E_valB", i, E_valB, v[i].evb);
      chk("E_dstM", i, 64'(E_dstM), 64'(v[i].edm));
      chk("bubble_cnt", i, 64'(bubble_cnt), 64'(v[i].bc));
      chk("stall_cnt", i, 64'(stall_cnt), 64'(v[i].sc));
    end

    // jxx then mispredict bubble: one bubble per pair, 4 -> 15 after 11 pairs
    for (int i = 0; i < 11; i++) begin
      simple(4'h7, 1'b0, 4'h1);
      simple(4'h6, 1'b0, 4'h1);
    end
    #1 chk("bcnt_full", 0, 64'(bubble_cnt), 64'hF);
    for (int i = 0; i < 3; i++) begin
      simple(4'h7, 1'b0, 4'h1);
      simple(4'h6, 1'b0, 4'h1);
    end
    #1 chk("bcnt_sat", 0, 64'(bubble_cnt), 64'hF);
    chk("scnt_pre", 0, 64'(stall_cnt), 64'h8);
    repeat (10) simple(4'h6, 1'b0, 4'h9);
    #1 chk("scnt_sat", 0, 64'(stall_cnt), 64'hF);

    @(negedge clk);
    d_icode = 4'h6; d_valA = 64'h55; M_icode = 4'h1;
    @(posedge clk);
    #1 chk("pre_arst", 0, E_valA, 64'h55);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_icode", 0, 64'(E_icode), 64'h1);
    chk("arst_valA", 0, E_valA, 64'h0);
    chk("arst_cnt", 0, 64'({bubble_cnt, stall_cnt}), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/execute_reg.md
# execute_reg

Pipeline register between decode and execute in the five-stage Y86-64 pipeline, with the hazard-control logic that governs it. Each cycle it captures the decode-stage outputs (`d_*`) into the E register, or inserts a bubble when a bubble is required. It computes the fetch/decode stall and bubble signals for load/use hazards, mispredicted conditional jumps and `ret`. It also keeps saturating event counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the bubble and stall event counters

Ports (name, direction, width, meaning):
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- d_stat, d_icode, d_ifun  in  4 each  decode-stage status and instruction fields
- d_valC, d_valA, d_valB  in  64 each  signed decode-stage values, after forwarding
- d_dstE, d_dstM, d_srcA, d_srcB  in  4 each  decode-stage register IDs; 15 means none
- e_Cnd  in  1  branch condition computed by execute for the instruction now in E
- M_icode  in  4  icode held in the M register
- W_stat  in  4  status held in the W register
- E_stat, E_icode, E_ifun  out  4 each  E register fields
- E_valC, E_valA, E_valB  out  64 each  E register values
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  E register IDs
- F_stall, D_stall, D_bubble, E_bubble  out  1 each  combinational pipeline-control outputs
- bubble_cnt, stall_cnt  out  CNT_W each  saturating event counters

## Operation
- Encodings: AOK = 1; icode NOP = 1, JXX = 7, MRMOVQ = 5, POPQ = B, RET = 9.
- Bubble value of the E register:
  - stat = 1, icode = 1, ifun = 0
  - valC, valA and valB = 0
  - dstE, dstM, srcA and srcB = 15
- Hazard terms, all computed from the current E register and inputs:
  - load_use = (E_icode is 5 or B) and E_dstM != 15 and (E_dstM == d_srcA or E_dstM == d_srcB)
  - mispredict = (E_icode == 7) and !e_Cnd
  - ret_haz = RET in d_icode, E_icode or M_icode
  - freeze = (W_stat != AOK)
- Control outputs:
  - F_stall = load_use or ret_haz
  - D_stall = load_use
  - D_bubble = mispredict or (ret_haz and !load_use)
  - E_bubble = (mispredict or load_use) and !freeze
- E register update on each rising edge, highest priority first:
  - freeze: hold all fields
  - E_bubble: load the bubble value
  - otherwise: load the `d_*` inputs unchanged
- bubble_cnt increments on every edge where E_bubble = 1. stall_cnt increments on every edge where F_stall = 1. Both saturate at all-ones and do not wrap. Neither counts while freeze = 1.
- valA, valB and valC are passed through bit-exact; the block does no arithmetic on them.

## Timing
- Reset (rst_n low, asynchronous): the E register takes the bubble value immediately and both counters are cleared. Asserting reset mid-instruction discards the E contents.
- With E_icode = 1 after reset, all hazard terms are 0. Control outputs are 0 unless `d_*`, M_icode or W_stat drive them.
- Latency: `d_*` appears on `E_*` one cycle after the edge that captures it.
- Control outputs are purely combinational in the same cycle and have no registered delay. The stage registers in the fetch and decode stages consume them at the same edge.
- load_use and mispredict together: one bubble is inserted, D_bubble = 1, D_stall = 1, and bubble_cnt increments by exactly 1.
- load_use with ret_haz: D_stall wins over D_bubble, and F_stall = 1.
- A d_srcA or d_srcB of 15 never matches E_dstM, because E_dstM = 15 is excluded from load_use.
- Reset is released synchronously to clk by the top level. The first capture happens at the first edge after rst_n rises.

## Test plan
- Reset: hold rst_n = 0 with random `d_*` inputs, then clock -> E_icode = 1, E_dstE = 15, E_valA = 0, bubble_cnt = 0, all control outputs 0.
- Pass-through: drive d_icode = 6, d_rA path with d_srcA = 2, d_valA = -143, d_valB = 101, d_dstE = 3 for one edge -> next cycle E_icode = 6, E_valA = -143, E_valB = 101, E_dstE = 3.
- Load/use: E holds icode 5 with E_dstM = 3; drive d_srcB = 3 -> F_stall = D_stall = E_bubble = 1 and D_bubble = 0; after the edge E holds the bubble and bubble_cnt = 1.
- Mispredict: E holds icode 7 and e_Cnd = 0 -> D_bubble = E_bubble = 1; after the edge E holds the bubble. Repeat with e_Cnd = 1 -> no bubble.
- Ret: M_icode = 9 for three cycles -> F_stall = D_bubble = 1 each cycle; stall_cnt = 3 and E loads the `d_*` inputs normally.
- Freeze and saturation: W_stat = 2 together with load_use -> E holds its contents, E_bubble = 0 and counters are unchanged. Separately, preload bubble_cnt to all-ones, then force a bubble -> bubble_cnt stays at all-ones.
